// File: rtl/rename_ckpt_ctrl.sv
// Branch checkpoint / allocation controller for the physical-register free list.
// Optional statistics counters are compiled in with `define FL_CKPT_STATS_EN.
module rename_ckpt_ctrl #(
  parameter int CKPT_DEPTH     = 8,
  parameter int TAG_W          = 3,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_grant,
  input  logic             ckpt_req,
  output logic             ckpt_grant,
  output logic [TAG_W-1:0] ckpt_tag,
  output logic             ckpt_full,
  input  logic             fl_empty,
  input  logic [6:0]       fl_r_ptr,
  input  logic [6:0]       fl_w_ptr,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_mispredict,
  output logic             fl_mispredict,
  output logic [6:0]       fl_re_r_ptr,
  output logic [6:0]       fl_re_w_ptr,
  output logic             commit_hold,
  output logic             recovering
`ifdef FL_CKPT_STATS_EN
  ,
  output logic [15:0]      stat_mispredicts,
  output logic [15:0]      stat_stall_cycles
`endif
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;
  localparam int         CNT_W   = 2;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TAG_W-1:0]      tail_q, tail_d;
  logic [CKPT_DEPTH-1:0] valid_q, valid_d;
  logic [6:0]            slot_ptr_q [CKPT_DEPTH];
  logic                  fl_mispredict_q, fl_mispredict_d;
  logic [6:0]            re_r_q, re_r_d;
  logic [6:0]            re_w_q, re_w_d;

  logic                  idle;
  logic                  tag_valid;
  logic                  mp_now;
  logic                  ok_now;
  logic                  full_now;
  logic [TAG_W-1:0]      span;
  logic [CKPT_DEPTH-1:0] squash;

  assign idle      = (state_q == IDLE);
  assign tag_valid = valid_q[resolve_tag];
  assign mp_now    = idle && resolve_valid && resolve_mispredict && tag_valid;
  assign ok_now    = idle && resolve_valid && !resolve_mispredict && tag_valid;
  assign full_now  = valid_q[tail_q];
  // Number of live checkpoints from the mispredicted one up to (not incl.) tail.
  assign span      = tail_q - resolve_tag;

  for (genvar gi = 0; gi < CKPT_DEPTH; gi++) begin : g_squash
    localparam logic [TAG_W-1:0] IDX = TAG_W'(gi);
    assign squash[gi] = full_now || ((IDX - resolve_tag) < span);
  end

  assign alloc_grant   = alloc_req && !fl_empty && idle && !mp_now;
  assign ckpt_grant    = ckpt_req && !full_now && idle && !mp_now;
  assign ckpt_tag      = tail_q;
  assign ckpt_full     = full_now;
  assign fl_mispredict = fl_mispredict_q;
  assign fl_re_r_ptr   = re_r_q;
  assign fl_re_w_ptr   = re_w_q;
  assign commit_hold   = !idle;
  assign recovering    = !idle;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tail_d          = tail_q;
    valid_d         = valid_q;
    fl_mispredict_d = 1'b0;
    re_r_d          = re_r_q;
    re_w_d          = re_w_q;
    if (ckpt_grant) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + TAG_W'(1);
    end
    if (ok_now) begin
      valid_d[resolve_tag] = 1'b0;
    end
    if (mp_now) begin
      valid_d         = valid_q & ~squash;
      tail_d          = resolve_tag;
      state_d         = RECOVER;
      cnt_d           = CNT_W'(RECOVER_CYCLES - 1);
      fl_mispredict_d = 1'b1;
      re_r_d          = slot_ptr_q[resolve_tag];
      re_w_d          = fl_w_ptr;
    end else if (!idle) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      tail_q          <= '0;
      valid_q         <= '0;
      fl_mispredict_q <= 1'b0;
      re_r_q          <= '0;
      re_w_q          <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tail_q          <= tail_d;
      valid_q         <= valid_d;
      fl_mispredict_q <= fl_mispredict_d;
      re_r_q          <= re_r_d;
      re_w_q          <= re_w_d;
    end
  end

  // Pointer payload needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (ckpt_grant) begin
      slot_ptr_q[tail_q] <= fl_r_ptr;
    end
  end

`ifdef FL_CKPT_STATS_EN
  logic [15:0] stat_mis_q, stat_mis_d;
  logic [15:0] stat_stall_q, stat_stall_d;
  logic        stall_now;

  assign stall_now = (alloc_req && !alloc_grant) || (ckpt_req && !ckpt_grant);

  always_comb begin
    stat_mis_d   = stat_mis_q;
    stat_stall_d = stat_stall_q;
    if (mp_now && (stat_mis_q != 16'hFFFF)) begin
      stat_mis_d = stat_mis_q + 16'd1;
    end
    if (stall_now && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_mis_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_mis_q   <= stat_mis_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_mispredicts  = stat_mis_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_rename_ckpt_ctrl.sv
// Directed bench for rename_ckpt_ctrl: one instance with RECOVER_CYCLES=1 and
// one with RECOVER_CYCLES=3 sharing the same input stimulus.
module tb_rename_ckpt_ctrl;
  logic       clk;
  logic       reset;
  logic       alloc_req;
  logic       ckpt_req;
  logic       fl_empty;
  logic [6:0] fl_r_ptr;
  logic [6:0] fl_w_ptr;
  logic       resolve_valid;
  logic [2:0] resolve_tag;
  logic       resolve_mispredict;

  logic       alloc_grant, ckpt_grant, ckpt_full, fl_mispredict, commit_hold, recovering;
  logic [2:0] ckpt_tag;
  logic [6:0] fl_re_r_ptr, fl_re_w_ptr;

  logic       r3_alloc_grant, r3_ckpt_grant, r3_ckpt_full, r3_fl_mispredict, r3_commit_hold, r3_recovering;
  logic [2:0] r3_ckpt_tag;
  logic [6:0] r3_fl_re_r_ptr, r3_fl_re_w_ptr;

`ifdef FL_CKPT_STATS_EN
  logic [15:0] stat_mis, stat_stall, r3_stat_mis, r3_stat_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rename_ckpt_ctrl #(.CKPT_DEPTH(8), .TAG_W(3), .RECOVER_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant),
    .ckpt_req(ckpt_req), .ckpt_grant(ckpt_grant), .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
    .fl_empty(fl_empty), .fl_r_ptr(fl_r_ptr), .fl_w_ptr(fl_w_ptr),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
    .fl_mispredict(fl_mispredict), .fl_re_r_ptr(fl_re_r_ptr), .fl_re_w_ptr(fl_re_w_ptr),
    .commit_hold(commit_hold), .recovering(recovering)
`ifdef FL_CKPT_STATS_EN
    , .stat_mispredicts(stat_mis), .stat_stall_cycles(stat_stall)
`endif
  );

  rename_ckpt_ctrl #(.CKPT_DEPTH(8), .TAG_W(3), .RECOVER_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_grant(r3_alloc_grant),
    .ckpt_req(ckpt_req), .ckpt_grant(r3_ckpt_grant), .ckpt_tag(r3_ckpt_tag), .ckpt_full(r3_ckpt_full),
    .fl_empty(fl_empty), .fl_r_ptr(fl_r_ptr), .fl_w_ptr(fl_w_ptr),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
    .fl_mispredict(r3_fl_mispredict), .fl_re_r_ptr(r3_fl_re_r_ptr), .fl_re_w_ptr(r3_fl_re_w_ptr),
    .commit_hold(r3_commit_hold), .recovering(r3_recovering)
`ifdef FL_CKPT_STATS_EN
    , .stat_mispredicts(r3_stat_mis), .stat_stall_cycles(r3_stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_req = 0; ckpt_req = 0; fl_empty = 0; fl_r_ptr = 0; fl_w_ptr = 0;
    resolve_valid = 0; resolve_tag = 0; resolve_mispredict = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    tick();
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    #3;
    n_cmp++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL rst_alloc_grant: got %b want 0", alloc_grant); end
    n_cmp++; if (ckpt_grant !== 1'b0) begin n_err++; $display("FAIL rst_ckpt_grant: got %b want 0", ckpt_grant); end
    n_cmp++; if (ckpt_tag !== 3'd0) begin n_err++; $display("FAIL rst_ckpt_tag: got %0d want 0", ckpt_tag); end
    n_cmp++; if (ckpt_full !== 1'b0) begin n_err++; $display("FAIL rst_ckpt_full: got %b want 0", ckpt_full); end
    n_cmp++; if (fl_mispredict !== 1'b0) begin n_err++; $display("FAIL rst_fl_mispredict: got %b want 0", fl_mispredict); end
    n_cmp++; if (fl_re_r_ptr !== 7'd0 || fl_re_w_ptr !== 7'd0) begin n_err++; $display("FAIL rst_re_ptrs: got r=%0d w=%0d want 0/0", fl_re_r_ptr, fl_re_w_ptr); end
    n_cmp++; if (commit_hold !== 1'b0 || recovering !== 1'b0) begin n_err++; $display("FAIL rst_hold_recov: got %b/%b want 0/0", commit_hold, recovering); end
    tick();
    reset = 1;
    #1;
    n_cmp++; if (r3_recovering !== 1'b0 || r3_ckpt_tag !== 3'd0) begin n_err++; $display("FAIL rst_r3: got recov=%b tag=%0d want 0/0", r3_recovering, r3_ckpt_tag); end
  endtask

  task automatic test_alloc();
    alloc_req = 1; fl_empty = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (alloc_grant !== 1'b1) begin n_err++; $display("FAIL alloc_grant c%0d: got %b want 1", i, alloc_grant); end
      n_cmp++; if (fl_mispredict !== 1'b0 || recovering !== 1'b0) begin n_err++; $display("FAIL alloc_idle c%0d: got mp=%b recov=%b want 0/0", i, fl_mispredict, recovering); end
      tick();
    end
    fl_empty = 1;
    #1;
    n_cmp++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL alloc_empty: got %b want 0", alloc_grant); end
    clear_inputs();
  endtask

  task automatic test_ckpt_alloc();
    ckpt_req = 1; alloc_req = 1; fl_r_ptr = 7'd40;
    #1;
    n_cmp++; if (ckpt_grant !== 1'b1 || ckpt_tag !== 3'd0) begin n_err++; $display("FAIL ckpt0: got grant=%b tag=%0d want 1/0", ckpt_grant, ckpt_tag); end
    n_cmp++; if (alloc_grant !== 1'b1) begin n_err++; $display("FAIL ckpt0_alloc: got %b want 1", alloc_grant); end
    tick();
    alloc_req = 0; fl_r_ptr = 7'd41;
    #1;
    n_cmp++; if (ckpt_grant !== 1'b1 || ckpt_tag !== 3'd1) begin n_err++; $display("FAIL ckpt1: got grant=%b tag=%0d want 1/1", ckpt_grant, ckpt_tag); end
    tick();
    ckpt_req = 0; alloc_req = 1;
    resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd0; fl_w_ptr = 7'd7;
    #1;
    n_cmp++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL mp_same_cycle_alloc: got %b want 0", alloc_grant); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (fl_mispredict !== 1'b1 || fl_re_r_ptr !== 7'd40 || fl_re_w_ptr !== 7'd7) begin n_err++; $display("FAIL slot0_restore: got mp=%b r=%0d w=%0d want 1/40/7", fl_mispredict, fl_re_r_ptr, fl_re_w_ptr); end
    tick();
    n_cmp++; if (recovering !== 1'b0 || ckpt_tag !== 3'd0 || ckpt_full !== 1'b0) begin n_err++; $display("FAIL slot0_after: got recov=%b tag=%0d full=%b want 0/0/0", recovering, ckpt_tag, ckpt_full); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      ckpt_req = 1; fl_r_ptr = 7'(60 + i);
      #1;
      n_cmp++; if (ckpt_grant !== 1'b1 || ckpt_tag !== 3'(i)) begin n_err++; $display("FAIL fill%0d: got grant=%b tag=%0d want 1/%0d", i, ckpt_grant, ckpt_tag, i); end
      tick();
    end
    #1;
    n_cmp++; if (ckpt_full !== 1'b1 || ckpt_grant !== 1'b0) begin n_err++; $display("FAIL full_9th: got full=%b grant=%b want 1/0", ckpt_full, ckpt_grant); end
    ckpt_req = 0; resolve_valid = 1; resolve_mispredict = 0; resolve_tag = 3'd0;
    tick();
    resolve_valid = 0;
    #1;
    n_cmp++; if (ckpt_full !== 1'b0) begin n_err++; $display("FAIL full_after_resolve: got %b want 0", ckpt_full); end
    ckpt_req = 1; fl_r_ptr = 7'd99;
    #1;
    n_cmp++; if (ckpt_grant !== 1'b1 || ckpt_tag !== 3'd0) begin n_err++; $display("FAIL reuse_tag0: got grant=%b tag=%0d want 1/0", ckpt_grant, ckpt_tag); end
    tick();
    ckpt_req = 0;
    #1;
    n_cmp++; if (ckpt_full !== 1'b1) begin n_err++; $display("FAIL full_again: got %b want 1", ckpt_full); end
    resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd3; fl_w_ptr = 7'd9;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (fl_mispredict !== 1'b1 || fl_re_r_ptr !== 7'd63 || fl_re_w_ptr !== 7'd9) begin n_err++; $display("FAIL full_mp_restore: got mp=%b r=%0d w=%0d want 1/63/9", fl_mispredict, fl_re_r_ptr, fl_re_w_ptr); end
    tick();
    n_cmp++; if (ckpt_full !== 1'b0 || ckpt_tag !== 3'd3) begin n_err++; $display("FAIL full_mp_tail: got full=%b tag=%0d want 0/3", ckpt_full, ckpt_tag); end
    // Tag 2 is older than 3 but must also have been squashed because the ring was full.
    alloc_req = 1; resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd2;
    #1;
    n_cmp++; if (alloc_grant !== 1'b1) begin n_err++; $display("FAIL stale_alloc: got %b want 1", alloc_grant); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (fl_mispredict !== 1'b0 || recovering !== 1'b0 || ckpt_tag !== 3'd3 || fl_re_r_ptr !== 7'd63) begin n_err++; $display("FAIL stale_ignored: got mp=%b recov=%b tag=%0d r=%0d want 0/0/3/63", fl_mispredict, recovering, ckpt_tag, fl_re_r_ptr); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ckpt_req = 1; fl_r_ptr = 7'(40 + 5 * i);
      tick();
    end
    ckpt_req = 0; fl_w_ptr = 7'd20;
    resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd1;
    tick();
    clear_inputs();
    alloc_req = 1; fl_w_ptr = 7'd33;
    #1;
    n_cmp++; if (fl_mispredict !== 1'b1 || fl_re_r_ptr !== 7'd45 || fl_re_w_ptr !== 7'd20) begin n_err++; $display("FAIL mp1_restore: got mp=%b r=%0d w=%0d want 1/45/20", fl_mispredict, fl_re_r_ptr, fl_re_w_ptr); end
    n_cmp++; if (commit_hold !== 1'b1 || recovering !== 1'b1 || alloc_grant !== 1'b0) begin n_err++; $display("FAIL mp1_recover: got hold=%b recov=%b alloc=%b want 1/1/0", commit_hold, recovering, alloc_grant); end
    tick();
    alloc_req = 0;
    #1;
    n_cmp++; if (recovering !== 1'b0 || fl_mispredict !== 1'b0 || ckpt_tag !== 3'd1 || ckpt_full !== 1'b0) begin n_err++; $display("FAIL mp1_idle: got recov=%b mp=%b tag=%0d full=%b want 0/0/1/0", recovering, fl_mispredict, ckpt_tag, ckpt_full); end
    n_cmp++; if (fl_re_r_ptr !== 7'd45 || fl_re_w_ptr !== 7'd20) begin n_err++; $display("FAIL mp1_hold: got r=%0d w=%0d want 45/20", fl_re_r_ptr, fl_re_w_ptr); end
    resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd3;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (fl_mispredict !== 1'b0 || ckpt_tag !== 3'd1) begin n_err++; $display("FAIL mp1_young_cleared: got mp=%b tag=%0d want 0/1", fl_mispredict, ckpt_tag); end
    resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd0; fl_w_ptr = 7'd21;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (fl_mispredict !== 1'b1 || fl_re_r_ptr !== 7'd40 || fl_re_w_ptr !== 7'd21) begin n_err++; $display("FAIL mp0_survived: got mp=%b r=%0d w=%0d want 1/40/21", fl_mispredict, fl_re_r_ptr, fl_re_w_ptr); end
    tick();
  endtask

  task automatic test_recover3();
    do_reset();
    ckpt_req = 1; fl_r_ptr = 7'd70;
    tick();
    fl_r_ptr = 7'd71;
    tick();
    ckpt_req = 0; resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd1; fl_w_ptr = 7'd5;
    tick();
    clear_inputs();
    // First RECOVER cycle: a correct resolve of live tag 0 plus requests, all to be ignored.
    resolve_valid = 1; resolve_mispredict = 0; resolve_tag = 3'd0; ckpt_req = 1; alloc_req = 1;
    #1;
    n_cmp++; if (r3_fl_mispredict !== 1'b1 || r3_recovering !== 1'b1 || r3_fl_re_r_ptr !== 7'd71) begin n_err++; $display("FAIL r3_c1: got mp=%b recov=%b r=%0d want 1/1/71", r3_fl_mispredict, r3_recovering, r3_fl_re_r_ptr); end
    n_cmp++; if (r3_ckpt_grant !== 1'b0 || r3_alloc_grant !== 1'b0) begin n_err++; $display("FAIL r3_c1_block: got ckpt=%b alloc=%b want 0/0", r3_ckpt_grant, r3_alloc_grant); end
    tick();
    clear_inputs();
    resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd0;
    #1;
    n_cmp++; if (r3_fl_mispredict !== 1'b0 || r3_recovering !== 1'b1 || r3_commit_hold !== 1'b1) begin n_err++; $display("FAIL r3_c2: got mp=%b recov=%b hold=%b want 0/1/1", r3_fl_mispredict, r3_recovering, r3_commit_hold); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (r3_fl_mispredict !== 1'b0 || r3_recovering !== 1'b1) begin n_err++; $display("FAIL r3_c3: got mp=%b recov=%b want 0/1", r3_fl_mispredict, r3_recovering); end
    tick();
    n_cmp++; if (r3_recovering !== 1'b0 || r3_commit_hold !== 1'b0 || r3_ckpt_tag !== 3'd1) begin n_err++; $display("FAIL r3_c4_idle: got recov=%b hold=%b tag=%0d want 0/0/1", r3_recovering, r3_commit_hold, r3_ckpt_tag); end
    resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd0; fl_w_ptr = 7'd6;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (r3_fl_mispredict !== 1'b1 || r3_fl_re_r_ptr !== 7'd70 || r3_fl_re_w_ptr !== 7'd6) begin n_err++; $display("FAIL r3_tag0_kept: got mp=%b r=%0d w=%0d want 1/70/6", r3_fl_mispredict, r3_fl_re_r_ptr, r3_fl_re_w_ptr); end
  endtask

  task automatic test_reset_mid_recover();
    do_reset();
    ckpt_req = 1; fl_r_ptr = 7'd12;
    tick();
    ckpt_req = 0; resolve_valid = 1; resolve_mispredict = 1; resolve_tag = 3'd0; fl_w_ptr = 7'd3;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (fl_mispredict !== 1'b1 || r3_recovering !== 1'b1) begin n_err++; $display("FAIL mid_pre: got mp=%b r3_recov=%b want 1/1", fl_mispredict, r3_recovering); end
    reset = 0;
    #1;
    n_cmp++; if (fl_mispredict !== 1'b0 || commit_hold !== 1'b0 || recovering !== 1'b0) begin n_err++; $display("FAIL mid_reset: got mp=%b hold=%b recov=%b want 0/0/0", fl_mispredict, commit_hold, recovering); end
    n_cmp++; if (fl_re_r_ptr !== 7'd0 || fl_re_w_ptr !== 7'd0 || r3_recovering !== 1'b0 || r3_commit_hold !== 1'b0) begin n_err++; $display("FAIL mid_reset_rest: got r=%0d w=%0d r3_recov=%b r3_hold=%b want 0/0/0/0", fl_re_r_ptr, fl_re_w_ptr, r3_recovering, r3_commit_hold); end
    tick();
    reset = 1;
    #1;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_ckpt_alloc();
    test_full();
    test_mispredict();
    test_recover3();
    test_reset_mid_recover();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rename_ckpt_ctrl.md
Name: rename_ckpt_ctrl

Overview:
Branch-checkpoint and allocation controller for the physical-register free list. It gates rename allocation requests against free-list empty, full checkpoints and recovery. It snapshots the free-list read pointer when a branch dispatches. On a branch mispredict it runs a short recovery sequence that drives the free list's restore interface. It sits between rename/dispatch, the branch unit and the free list.

Parameters:
CKPT_DEPTH, 8, number of branch checkpoint slots (power of 2, 2..16)
TAG_W, 3, checkpoint tag width, equal to log2(CKPT_DEPTH)
RECOVER_CYCLES, 1, cycles spent in RECOVER (allocation blocked), 1..4

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
alloc_req  in  1  rename requests one physical register this cycle
alloc_grant  out  1  allocation accepted; also drives free list read_en
ckpt_req  in  1  branch dispatch requests a checkpoint; the branch is older than any same-cycle alloc
ckpt_grant  out  1  checkpoint taken this cycle
ckpt_tag  out  TAG_W  slot assigned to the granted checkpoint
ckpt_full  out  1  no free checkpoint slot
fl_empty  in  1  free list empty
fl_r_ptr  in  7  free list current read pointer
fl_w_ptr  in  7  free list current write pointer
resolve_valid  in  1  branch resolved
resolve_tag  in  TAG_W  tag of the resolved branch
resolve_mispredict  in  1  resolved branch was mispredicted
fl_mispredict  out  1  restore pulse to the free list
fl_re_r_ptr  out  7  restore read pointer
fl_re_w_ptr  out  7  restore write pointer
commit_hold  out  1  commit must not free registers this cycle
recovering  out  1  FSM is not in IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, tail=0, all valid bits 0. All outputs 0, except ckpt_tag=0.
- Storage: CKPT_DEPTH slots, each holding a valid bit and a 7-bit r_ptr. tail is a TAG_W-bit counter that wraps naturally. ckpt_full = valid[tail].
- FSM states: IDLE, RECOVER.
  - IDLE -> RECOVER when resolve_valid && resolve_mispredict && valid[resolve_tag].
  - RECOVER lasts RECOVER_CYCLES cycles (down-counter), then returns to IDLE.
- alloc_grant (combinational) = alloc_req && !fl_empty && IDLE && !mp_now, where mp_now is the IDLE->RECOVER condition.
- ckpt_grant (combinational) = ckpt_req && !ckpt_full && IDLE && !mp_now.
  - ckpt_tag = tail.
  - On the clock edge: slot[tail] <= {1, fl_r_ptr} (the pre-increment pointer, even if alloc_grant is also high); tail <= tail+1.
- Correct resolve (resolve_valid && !resolve_mispredict) in IDLE: clear valid[resolve_tag]. This may coincide with a ckpt_grant to a different slot.
- Mispredict resolve on tag t (cycle N), registered actions:
  - fl_re_r_ptr <= slot[t].r_ptr.
  - fl_re_w_ptr <= fl_w_ptr sampled at cycle N; commits are never undone.
  - Clear valid on t and every slot younger than t: indices (t+k) mod DEPTH for k in 0..((tail-t) mod DEPTH)-1. If ckpt_full at N, clear all slots.
  - tail <= t.
- Cycle N+1: fl_mispredict=1 for exactly one cycle. commit_hold=1 and recovering=1 for all RECOVER cycles.
- Resolves are ignored in RECOVER, and also when valid[resolve_tag]=0 (stale/squashed tag), including mispredicts.
- A correct resolve and a mispredict can never arrive in the same cycle (single resolve port).
- fl_re_*_ptr hold their last value outside recovery.
- Reset mid-RECOVER aborts recovery immediately, with all outputs returning to reset values.

Optional Feature:
FL_CKPT_STATS_EN:
- Defined: adds outputs stat_mispredicts[15:0] and stat_stall_cycles[15:0], both saturating at 16'hFFFF and reset to 0.
  - stat_mispredicts increments on each IDLE->RECOVER transition.
  - stat_stall_cycles increments each cycle with (alloc_req && !alloc_grant) || (ckpt_req && !ckpt_grant).
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then alloc_req=1 with fl_empty=0 for 3 cycles -> alloc_grant=1 each cycle; fl_mispredict=0; recovering=0.
- ckpt_req and alloc_req in the same cycle, fl_r_ptr=40 -> ckpt_grant=1, ckpt_tag=0, alloc_grant=1, slot0 stores 40. Next ckpt_req with fl_r_ptr=41 -> ckpt_tag=1.
- Take 8 checkpoints -> ckpt_full=1 and a 9th ckpt_req gets ckpt_grant=0. Correct resolve of tag 0 -> ckpt_full=0, and the next grant gives tag 0.
- Checkpoints tags 0..3 with r_ptr 40,45,50,55, fl_w_ptr=20; mispredict tag 1 at cycle N:
  - cycle N+1: fl_mispredict=1, fl_re_r_ptr=45, fl_re_w_ptr=20, commit_hold=1, alloc_grant=0 despite alloc_req.
  - cycle N+2: IDLE; next ckpt_tag=1; valid bits 1..3 cleared.
- Mispredict with RECOVER_CYCLES=3 -> recovering=1 for exactly 3 cycles and fl_mispredict only in the first. A resolve arriving during RECOVER is ignored.
- Mispredict on a stale tag (valid=0) -> no fl_mispredict and no state change. Assert reset mid-RECOVER -> fl_mispredict, commit_hold and recovering all drop to 0 immediately.
